mem_arbiter: RTL and testbench

- Shares one single-ported basic_mem between the CPU's instruction-fetch port and its data load/store port, so the core can run from a unified memory.
- Sits between the cpu instance and one basic_mem instance in the simulation top level.
- Registered grant FSM with data-side priority.
- A starvation counter guarantees that fetch makes forward progress.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int xlen = 32
);
  logic            i_req;
  logic [xlen-1:0] i_adr;
  logic [xlen-1:0] i_resp;
  logic            i_ack;

  logic            d_r_v;
  logic            d_w_v;
  logic [xlen-1:0] d_adr;
  logic [xlen-1:0] d_data;
  logic [3:0]      d_strobe;
  logic [xlen-1:0] d_resp;
  logic            d_ack;

  logic            m_r_v;
  logic            m_w_v;
  logic [xlen-1:0] m_adr;
  logic [xlen-1:0] m_data;
  logic [3:0]      m_strobe;
  logic [xlen-1:0] m_resp;
  logic            m_ack;

  modport slave (
    input  i_req, i_adr, d_r_v, d_w_v, d_adr, d_data, d_strobe, m_resp, m_ack,
    output i_resp, i_ack, d_resp, d_ack, m_r_v, m_w_v, m_adr, m_data, m_strobe
  );

  modport master (
    output i_req, i_adr, d_r_v, d_w_v, d_adr, d_data, d_strobe, m_resp, m_ack,
    input  i_resp, i_ack, d_resp, d_ack, m_r_v, m_w_v, m_adr, m_data, m_strobe
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// Data side has priority; a saturating starvation counter forces fetch through.
module mem_arbiter #(
  parameter int xlen       = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  state_t          state, state_nxt;
  logic [3:0]      starve_cnt, starve_nxt;
  logic            grant_i, grant_d;
  logic            d_req;
  logic            cap_r, cap_w;
  logic [xlen-1:0] cap_adr, cap_data;
  logic [3:0]      cap_strobe;
  logic [xlen-1:0] i_resp_q, d_resp_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_MAX) ? STARVE_MAX : v + 4'd1;
  endfunction

  assign d_req = bus.d_r_v | bus.d_w_v;

  always_comb begin
    state_nxt    = state;
    starve_nxt   = starve_cnt;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    bus.m_r_v    = 1'b0;
    bus.m_w_v    = 1'b0;
    bus.m_adr    = '0;
    bus.m_data   = '0;
    bus.m_strobe = '0;
    bus.i_ack    = 1'b0;
    bus.d_ack    = 1'b0;
    bus.i_resp   = i_resp_q;
    bus.d_resp   = d_resp_q;
    case (state)
      IDLE: begin
        if (bus.i_req && (starve_cnt == STARVE_MAX)) grant_i = 1'b1;
        else if (d_req)                             grant_d = 1'b1;
        else if (bus.i_req)                         grant_i = 1'b1;

        if (grant_i) begin
          state_nxt  = GNT_I;
          starve_nxt = 4'd0;
        end else if (grant_d) begin
          state_nxt  = GNT_D;
          starve_nxt = bus.i_req ? sat_inc(starve_cnt) : 4'd0;
        end else if (!bus.i_req) begin
          starve_nxt = 4'd0;
        end
      end
      GNT_I: begin
        bus.m_r_v = 1'b1;
        bus.m_adr = cap_adr;
        if (bus.m_ack) begin
          bus.i_ack  = 1'b1;
          bus.i_resp = bus.m_resp;
          state_nxt  = IDLE;
        end
      end
      GNT_D: begin
        bus.m_r_v    = cap_r & ~cap_w;
        bus.m_w_v    = cap_w;
        bus.m_adr    = cap_adr;
        bus.m_data   = cap_data;
        bus.m_strobe = cap_strobe;
        if (bus.m_ack) begin
          bus.d_ack  = 1'b1;
          bus.d_resp = bus.m_resp;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      cap_r      <= 1'b0;
      cap_w      <= 1'b0;
      i_resp_q   <= '0;
      d_resp_q   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (grant_i) begin
        cap_r <= 1'b1;
        cap_w <= 1'b0;
      end else if (grant_d) begin
        // A simultaneous read+write request collapses to the write.
        cap_r <= bus.d_r_v & ~bus.d_w_v;
        cap_w <= bus.d_w_v;
      end
      if (state == GNT_I && bus.m_ack) i_resp_q <= bus.m_resp;
      if (state == GNT_D && bus.m_ack) d_resp_q <= bus.m_resp;
    end
  end

  // Captured request fields; outputs are gated by state, so no reset is needed.
  always_ff @(posedge clk) begin
    if (grant_i) begin
      cap_adr    <= bus.i_adr;
      cap_data   <= '0;
      cap_strobe <= '0;
    end else if (grant_d) begin
      cap_adr    <= bus.d_adr;
      cap_data   <= bus.d_data;
      cap_strobe <= bus.d_strobe;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, conflict, reset
// and a zero-wait memory run against a reference memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        zw;
  logic        man_ack;
  logic [31:0] man_resp;
  logic        init_mem;
  logic [31:0] dev_mem [16];
  logic [31:0] ref_mem [16];
  int          tests  = 0;
  int          failed = 0;

  mem_arbiter_if #(.xlen(32)) bus ();

  mem_arbiter #(.xlen(32), .MAX_STARVE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.m_ack  = zw ? (bus.m_r_v | bus.m_w_v) : man_ack;
  assign bus.m_resp = zw ? dev_mem[bus.m_adr[5:2]] : man_resp;

  function automatic logic [31:0] seed(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= seed(i);
    end else if (zw && bus.m_w_v) begin
      for (int b = 0; b < 4; b++)
        if (bus.m_strobe[b]) dev_mem[bus.m_adr[5:2]][8*b +: 8] <= bus.m_data[8*b +: 8];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic zw_txn(input logic is_d, input logic r, input logic w, input logic [3:0] word,
                        input logic [31:0] dat, input logic [3:0] strb);
    int          n;
    logic        got;
    logic [31:0] exp_rd;
    exp_rd = ref_mem[word];
    if (is_d) begin
      bus.d_r_v    = r;
      bus.d_w_v    = w;
      bus.d_adr    = {26'd0, word, 2'b00};
      bus.d_data   = dat;
      bus.d_strobe = strb;
    end else begin
      bus.i_req = 1'b1;
      bus.i_adr = {26'd0, word, 2'b00};
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 4) begin
      tick;
      n++;
      got = is_d ? bus.d_ack : bus.i_ack;
    end
    check32("zw_latency", 32'(n), 32'd1);
    check1("zw_other_ack", is_d ? bus.i_ack : bus.d_ack, 1'b0);
    if (!is_d)   check32("zw_fetch_data", bus.i_resp, exp_rd);
    else if (!w) check32("zw_read_data", bus.d_resp, exp_rd);
    bus.i_req = 1'b0;
    bus.d_r_v = 1'b0;
    bus.d_w_v = 1'b0;
    if (is_d && w)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[word][8*b +: 8] = dat[8*b +: 8];
    tick;
    check1("zw_dup_i_ack", bus.i_ack, 1'b0);
    check1("zw_dup_d_ack", bus.d_ack, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_d;
    logic        got_i;
    logic [3:0]  word;
    int          sel;

    rst          = 1'b1;
    zw           = 1'b0;
    man_ack      = 1'b0;
    man_resp     = '0;
    init_mem     = 1'b0;
    bus.i_req    = 1'b0;
    bus.i_adr    = '0;
    bus.d_r_v    = 1'b0;
    bus.d_w_v    = 1'b0;
    bus.d_adr    = '0;
    bus.d_data   = '0;
    bus.d_strobe = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = seed(i);

    tick;
    tick;
    check1("rst_m_r_v", bus.m_r_v, 1'b0);
    check1("rst_m_w_v", bus.m_w_v, 1'b0);
    check1("rst_i_ack", bus.i_ack, 1'b0);
    check1("rst_d_ack", bus.d_ack, 1'b0);
    check32("rst_i_resp", bus.i_resp, 32'd0);
    check32("rst_d_resp", bus.d_resp, 32'd0);
    rst      = 1'b0;
    init_mem = 1'b1;
    tick;
    init_mem = 1'b0;

    // Fetch only, memory answers one cycle after m_r_v.
    bus.i_req = 1'b1;
    bus.i_adr = 32'h100;
    tick;
    check1("fetch_m_r_v_c1", bus.m_r_v, 1'b1);
    check32("fetch_m_adr_c1", bus.m_adr, 32'h100);
    check1("fetch_m_w_v_c1", bus.m_w_v, 1'b0);
    check32("fetch_m_strobe_c1", 32'(bus.m_strobe), 32'd0);
    check1("fetch_i_ack_c1", bus.i_ack, 1'b0);
    tick;
    check1("fetch_i_ack_wait", bus.i_ack, 1'b0);
    man_ack  = 1'b1;
    man_resp = 32'h0000_0013;
    #1;
    check1("fetch_i_ack_c2", bus.i_ack, 1'b1);
    check32("fetch_i_resp_c2", bus.i_resp, 32'h13);
    check1("fetch_d_ack_c2", bus.d_ack, 1'b0);
    bus.i_adr = 32'h104;
    tick;
    man_ack = 1'b0;
    check1("fetch_idle_m_r_v_c3", bus.m_r_v, 1'b0);
    check1("fetch_idle_i_ack_c3", bus.i_ack, 1'b0);
    check32("fetch_i_resp_hold", bus.i_resp, 32'h13);
    tick;
    check1("fetch2_m_r_v_c4", bus.m_r_v, 1'b1);
    check32("fetch2_m_adr_c4", bus.m_adr, 32'h104);
    man_ack  = 1'b1;
    man_resp = 32'h0000_0093;
    #1;
    check32("fetch2_i_resp", bus.i_resp, 32'h93);
    bus.i_req = 1'b0;
    tick;
    man_ack = 1'b0;

    // Simultaneous fetch and data write: data first.
    bus.i_req    = 1'b1;
    bus.i_adr    = 32'h200;
    bus.d_w_v    = 1'b1;
    bus.d_adr    = 32'h2000;
    bus.d_data   = 32'hDEAD_BEEF;
    bus.d_strobe = 4'b0011;
    tick;
    check1("sim_m_w_v", bus.m_w_v, 1'b1);
    check1("sim_m_r_v", bus.m_r_v, 1'b0);
    check32("sim_m_adr", bus.m_adr, 32'h2000);
    check32("sim_m_data", bus.m_data, 32'hDEAD_BEEF);
    check32("sim_m_strobe", 32'(bus.m_strobe), 32'h3);
    man_ack = 1'b1;
    #1;
    check1("sim_d_ack", bus.d_ack, 1'b1);
    check1("sim_i_ack_low", bus.i_ack, 1'b0);
    bus.d_w_v = 1'b0;
    tick;
    man_ack = 1'b0;
    check1("sim_idle_m_r_v", bus.m_r_v, 1'b0);
    check1("sim_idle_d_ack", bus.d_ack, 1'b0);
    tick;
    check1("sim_fetch_m_r_v", bus.m_r_v, 1'b1);
    check32("sim_fetch_m_adr", bus.m_adr, 32'h200);
    check32("sim_fetch_m_data", bus.m_data, 32'd0);
    man_ack  = 1'b1;
    man_resp = 32'h1111_2222;
    #1;
    check1("sim_fetch_i_ack", bus.i_ack, 1'b1);
    bus.i_req = 1'b0;
    tick;
    man_ack = 1'b0;

    // Starvation: fetch held while data reads keep coming.
    bus.i_req = 1'b1;
    bus.i_adr = 32'h300;
    bus.d_r_v = 1'b1;
    bus.d_adr = 32'h3000;
    n_d   = 0;
    got_i = 1'b0;
    for (int g = 0; g < 8 && !got_i; g++) begin
      tick;
      if (bus.m_r_v && bus.m_adr == 32'h300)       got_i = 1'b1;
      else if (bus.m_r_v && bus.m_adr == 32'h3000) n_d++;
      man_ack  = 1'b1;
      man_resp = 32'h0000_0077;
      #1;
      if (!got_i) begin
        check1("starve_d_ack", bus.d_ack, 1'b1);
        tick;
        man_ack = 1'b0;
      end
    end
    check32("starve_data_grants", 32'(n_d), 32'd4);
    check1("starve_fetch_granted", got_i, 1'b1);
    check1("starve_i_ack", bus.i_ack, 1'b1);
    check32("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
    bus.i_req = 1'b0;
    tick;
    man_ack = 1'b0;
    tick;
    check1("starve_after_d_grant", bus.m_r_v, 1'b1);
    check32("starve_after_d_adr", bus.m_adr, 32'h3000);
    man_ack = 1'b1;
    #1;
    check1("starve_after_d_ack", bus.d_ack, 1'b1);
    bus.d_r_v = 1'b0;
    tick;
    man_ack = 1'b0;
    check32("starve_cnt_idle", 32'(dut.starve_cnt), 32'd0);

    // Read and write together: the write wins, one ack.
    bus.d_r_v    = 1'b1;
    bus.d_w_v    = 1'b1;
    bus.d_adr    = 32'h40;
    bus.d_data   = 32'h1122_3344;
    bus.d_strobe = 4'hF;
    tick;
    check1("rw_m_w_v", bus.m_w_v, 1'b1);
    check1("rw_m_r_v", bus.m_r_v, 1'b0);
    tick;
    check1("rw_no_early_ack", bus.d_ack, 1'b0);
    man_ack  = 1'b1;
    man_resp = 32'h0000_0055;
    #1;
    check1("rw_d_ack", bus.d_ack, 1'b1);
    bus.d_r_v = 1'b0;
    bus.d_w_v = 1'b0;
    tick;
    man_ack = 1'b0;
    check1("rw_single_ack_a", bus.d_ack, 1'b0);
    tick;
    check1("rw_single_ack_b", bus.d_ack, 1'b0);
    check1("rw_idle_m_w_v", bus.m_w_v, 1'b0);

    // Asynchronous reset in the middle of a data write grant.
    bus.d_w_v    = 1'b1;
    bus.d_adr    = 32'h80;
    bus.d_data   = 32'hCAFE_F00D;
    bus.d_strobe = 4'hF;
    tick;
    check1("ar_pre_m_w_v", bus.m_w_v, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check1("ar_m_w_v", bus.m_w_v, 1'b0);
    check1("ar_m_r_v", bus.m_r_v, 1'b0);
    check32("ar_m_adr", bus.m_adr, 32'd0);
    check32("ar_m_data", bus.m_data, 32'd0);
    check32("ar_m_strobe", 32'(bus.m_strobe), 32'd0);
    check1("ar_d_ack", bus.d_ack, 1'b0);
    check32("ar_i_resp", bus.i_resp, 32'd0);
    check32("ar_d_resp", bus.d_resp, 32'd0);
    bus.d_w_v = 1'b0;
    man_ack   = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
    check1("ar_stale_d_ack", bus.d_ack, 1'b0);
    check1("ar_stale_i_ack", bus.i_ack, 1'b0);
    check1("ar_idle_m_w_v", bus.m_w_v, 1'b0);
    man_ack = 1'b0;

    // Zero-wait memory, alternating fetch and data against the reference model.
    zw = 1'b1;
    for (int k = 0; k < 100; k++) begin
      word = 4'($urandom_range(0, 15));
      if (k % 2 == 0) begin
        zw_txn(1'b0, 1'b0, 1'b0, word, 32'd0, 4'd0);
      end else begin
        sel = $urandom_range(0, 2);
        zw_txn(1'b1, sel != 1, sel != 0, word, $urandom, 4'($urandom_range(1, 15)));
      end
    end
    for (int i = 0; i < 16; i++) begin
      zw_txn(1'b1, 1'b1, 1'b0, 4'(i), 32'd0, 4'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
